// File: rtl/spi_rx_slave.sv
// +----------------------------------------------------------------------------+
// | spi_rx_slave                                                               |
// | SPI receive endpoint: oversamples CS/SCLK/SDI on clk, deserialises words   |
// | MSB-first onto a valid/ready port, flags framing errors and overruns.      |
// | Optional feature macro: SPI_RX_DC_EN (captures SPI_DC alongside each word) |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_rx_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs,
  input  logic                  spi_sclk,
  input  logic                  spi_sdi,
  input  logic                  spi_dc,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_dc,
  output logic                  rx_end,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  ovr_clr
);

  localparam int                c_CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_cs_d;
  logic                   r_sclk_d;
  logic                   w_cs_q;
  logic                   w_sclk_q;
  logic                   w_cs_rise;
  logic                   w_sclk_rise;

  assign w_cs_q      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_q    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_rise   = w_cs_q & ~r_cs_d;
  assign w_sclk_rise = w_sclk_q & ~r_sclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '1;
      r_sdi_sync  <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b1;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      r_cs_d      <= w_cs_q;
      r_sclk_d    <= w_sclk_q;
    end
  end

  // Edge events are registered together so a CS release and the final SCLK
  // edge landing in the same synced cycle are seen by the FSM at once.
  logic r_rise_p;
  logic r_cs_rise_p;
  logic r_cs_p;
  logic r_bit_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_p    <= 1'b0;
      r_cs_rise_p <= 1'b0;
      r_cs_p      <= 1'b1;
      r_bit_p     <= 1'b0;
    end else begin
      r_rise_p    <= w_sclk_rise;
      r_cs_rise_p <= w_cs_rise;
      r_cs_p      <= w_cs_q;
      r_bit_p     <= r_sdi_sync[SYNC_STAGES-1];
    end
  end

`ifdef SPI_RX_DC_EN
  logic [SYNC_STAGES-1:0] r_dc_sync;
  logic                   r_dc_p;
  logic                   r_word_dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dc_sync <= '0;
      r_dc_p    <= 1'b0;
    end else begin
      r_dc_sync <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc};
      r_dc_p    <= r_dc_sync[SYNC_STAGES-1];
    end
  end
`else
  logic w_unused_dc;
  assign w_unused_dc = spi_dc;
  assign rx_dc       = 1'b0;
`endif

  // Receive FSM
  state_t                r_state;
  logic [c_CNT_W-1:0]    r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_word_done;
  logic                  r_end_p;
  logic                  r_ferr_p;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_last;
  logic [c_CNT_W-1:0]    w_cnt_next;

  assign w_word     = {r_shreg[DATA_WIDTH-2:0], r_bit_p};
  assign w_last     = r_rise_p && (r_bit_cnt == c_LAST_BIT);
  assign w_cnt_next = !r_rise_p ? r_bit_cnt :
                      (w_last ? '0 : r_bit_cnt + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_word      <= '0;
      r_word_done <= 1'b0;
      r_end_p     <= 1'b0;
      r_ferr_p    <= 1'b0;
`ifdef SPI_RX_DC_EN
      r_word_dc   <= 1'b0;
`endif
    end else begin
      r_word_done <= 1'b0;
      r_end_p     <= 1'b0;
      r_ferr_p    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_cs_p) begin
            r_state   <= ST_RECV;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
          end
        end
        ST_RECV: begin
          if (r_rise_p) begin
            r_shreg   <= w_word;
            r_bit_cnt <= w_cnt_next;
          end
          if (w_last) begin
            r_word      <= w_word;
            r_word_done <= 1'b1;
`ifdef SPI_RX_DC_EN
            r_word_dc   <= r_dc_p;
`endif
          end
          // Boundary test uses the post-sample count so a coincident final bit ends cleanly.
          if (r_cs_rise_p) begin
            r_state <= ST_IDLE;
            if (w_cnt_next == '0) begin
              r_end_p <= 1'b1;
            end else begin
              r_ferr_p <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output stage: handshake, pulses and overrun tracking
  logic w_accept;
  logic w_ovr_set;

  assign w_accept  = rx_valid & rx_ready;
  assign w_ovr_set = r_word_done & rx_valid & ~rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_end    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SPI_RX_DC_EN
      rx_dc     <= 1'b0;
`endif
    end else begin
      rx_end    <= r_end_p;
      frame_err <= r_ferr_p;
      if (r_word_done) begin
        rx_data  <= r_word;
        rx_valid <= 1'b1;
`ifdef SPI_RX_DC_EN
        rx_dc    <= r_word_dc;
`endif
      end else if (w_accept) begin
        rx_valid <= 1'b0;
      end
      if (w_ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_rx_slave.sv
// +----------------------------------------------------------------------------+
// | tb_spi_rx_slave                                                            |
// | Directed self-checking bench for spi_rx_slave.                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_rx_slave;

  localparam int c_SYNC = 2;
  localparam int c_LAT  = c_SYNC + 2;
  localparam int c_HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs, spi_sclk, spi_sdi, spi_dc;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_dc, rx_end, frame_err, overrun, ovr_clr;

  int errors = 0;
  int checks = 0;
  int lat    = 0;

  int n_end = 0, n_ferr = 0, n_words = 0, n_vcyc = 0;
  int b_end, b_ferr, b_words, b_vcyc;
  logic [7:0] last_word = 8'h00;
  logic       last_dc   = 1'b0;
  logic       prev_valid = 1'b0;

  spi_rx_slave #(.DATA_WIDTH(8), .SYNC_STAGES(c_SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_sdi(spi_sdi), .spi_dc(spi_dc), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_dc(rx_dc), .rx_end(rx_end), .frame_err(frame_err),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_end) n_end++;
    if (frame_err) n_ferr++;
    if (rx_valid) n_vcyc++;
    if (rx_valid && !prev_valid) begin
      n_words++;
      last_word = rx_data;
      last_dc   = rx_dc;
    end
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_end = n_end; b_ferr = n_ferr; b_words = n_words; b_vcyc = n_vcyc;
  endtask

  task automatic cs_low();
    @(negedge clk); spi_cs = 1'b0;
    repeat (c_HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk); spi_cs = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  // mode: 0 plain, 1 measure latency, 2 rx_ready on completion cycle,
  //       3 drop ovr_clr after completion cycle, 4 CS rises with final SCLK edge
  task automatic send_word(input logic [7:0] d, input int nbits, input logic dc_v, input int mode);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      spi_sclk = 1'b0; spi_sdi = d[7-i]; spi_dc = dc_v;
      repeat (c_HALF) @(negedge clk);
      spi_sclk = 1'b1;
      if (i == nbits - 1) begin
        if (mode == 4) spi_cs = 1'b1;
        if (mode == 1) begin
          @(posedge clk);
          lat = 0;
          while (lat < 20) begin
            @(posedge clk); #1; lat++;
            if (rx_valid) break;
          end
        end else if (mode == 2) begin
          @(posedge clk);
          repeat (c_LAT - 1) @(posedge clk);
          #1 rx_ready = 1'b1;
          @(posedge clk);
          #1 rx_ready = 1'b0;
        end else if (mode == 3) begin
          @(posedge clk);
          repeat (c_LAT) @(posedge clk);
          #1 ovr_clr = 1'b0;
        end
      end
      repeat (c_HALF) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b1; spi_sdi = 1'b0; spi_dc = 1'b0;
    rx_ready = 1'b0; ovr_clr = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_flags", {rx_end, frame_err, overrun, rx_dc}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame 0xA5 with consumer ready
    rx_ready = 1'b1;
    snap();
    cs_low();
    send_word(8'hA5, 8, 1'b0, 1);
    cs_high();
    check("a5_latency", lat, c_LAT);
    check("a5_data", last_word, 8'hA5);
    check("a5_words", n_words - b_words, 1);
    check("a5_valid_cycles", n_vcyc - b_vcyc, 1);
    check("a5_end", n_end - b_end, 1);
    check("a5_ferr", n_ferr - b_ferr, 0);
    check("a5_overrun", overrun, 0);

    // Burst 0x3C, 0xF0 without acceptance -> overrun
    rx_ready = 1'b0;
    snap();
    cs_low();
    send_word(8'h3C, 8, 1'b0, 0);
    send_word(8'hF0, 8, 1'b0, 0);
    cs_high();
    check("burst_data", rx_data, 8'hF0);
    check("burst_valid", rx_valid, 1);
    check("burst_overrun", overrun, 1);
    check("burst_end", n_end - b_end, 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("ovr_clr_overrun", overrun, 0);
    check("ovr_clr_valid", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("accept_clears_valid", rx_valid, 0);

    // Partial frame then a full frame
    snap();
    cs_low();
    send_word(8'hA5, 5, 1'b0, 0);
    cs_high();
    check("partial_ferr", n_ferr - b_ferr, 1);
    check("partial_end", n_end - b_end, 0);
    check("partial_words", n_words - b_words, 0);
    check("partial_valid", rx_valid, 0);
    snap();
    cs_low();
    send_word(8'h3C, 8, 1'b0, 0);
    cs_high();
    check("after_partial_data", last_word, 8'h3C);
    check("after_partial_end", n_end - b_end, 1);

    // Acceptance coinciding with completion of the second burst word
    rx_ready = 1'b0;
    cs_low();
    send_word(8'h11, 8, 1'b0, 0);
    check("coinc_first_data", rx_data, 8'h11);
    send_word(8'h22, 8, 1'b0, 2);
    cs_high();
    check("coinc_data", rx_data, 8'h22);
    check("coinc_valid", rx_valid, 1);
    check("coinc_overrun", overrun, 0);

    // Overrun set while ovr_clr is asserted: set wins
    ovr_clr = 1'b1;
    cs_low();
    send_word(8'h96, 8, 1'b0, 3);
    cs_high();
    check("setwins_overrun", overrun, 1);
    check("setwins_data", rx_data, 8'h96);

    // Asynchronous reset mid-word with SCLK toggling
    cs_low();
    send_word(8'hFF, 3, 1'b0, 0);
    @(negedge clk); spi_sclk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_flags", {rx_end, frame_err, overrun, rx_dc}, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); spi_sclk = ~spi_sclk;
    end
    spi_cs = 1'b1; spi_sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap();
    repeat (40) @(negedge clk);
    check("post_rst_pulses", (n_end - b_end) + (n_ferr - b_ferr), 0);
    check("post_rst_words", n_words - b_words, 0);
    check("post_rst_valid", rx_valid, 0);

    // CS release coinciding with the final SCLK edge
    rx_ready = 1'b1;
    snap();
    cs_low();
    send_word(8'hC3, 8, 1'b0, 4);
    cs_high();
    check("coedge_data", last_word, 8'hC3);
    check("coedge_end", n_end - b_end, 1);
    check("coedge_ferr", n_ferr - b_ferr, 0);

    // DC tagging
`ifdef SPI_RX_DC_EN
    cs_low();
    send_word(8'h81, 8, 1'b0, 0);
    cs_high();
    check("dc_word0_data", last_word, 8'h81);
    check("dc_word0_dc", last_dc, 0);
    cs_low();
    send_word(8'h55, 8, 1'b1, 0);
    cs_high();
    check("dc_word1_data", last_word, 8'h55);
    check("dc_word1_dc", last_dc, 1);
`else
    cs_low();
    send_word(8'h55, 8, 1'b1, 0);
    cs_high();
    check("nodc_data", last_word, 8'h55);
    check("nodc_dc", last_dc, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
